// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding select
// encoding and data-memory handshake states.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one EX source operand; the M-stage result wins over
// W because it is the younger write to the same register.
module fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 4
) (
  input  logic [RA_W-1:0] RAE,
  input  logic [RA_W-1:0] WA3M,
  input  logic [RA_W-1:0] WA3W,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  output fwd_sel_t        fwd
);

  always_comb begin
    // NOTE: default first so every path assigns fwd and no latch is inferred.
    fwd = FWD_RF;
    if (RegWriteM && (WA3M == RAE))      fwd = FWD_M;
    else if (RegWriteW && (WA3W == RAE)) fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and data-memory
// stalls, branch flushes and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W        = 4,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  RA1E,
  input  logic [RA_W-1:0]  RA2E,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [RA_W-1:0]  WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchTakenE,
  input  logic             MemAck,
  input  logic             CntClr,
  output logic             MemReq,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int             WT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WT_W-1:0] TIMEOUT_V = WT_W'(MEM_TIMEOUT);

  fwd_sel_t   fwd_a, fwd_b;
  mem_state_t state, next_state;
  logic [WT_W-1:0] wait_cnt, next_wait;
  logic memop, memstall, lwstall, set_err;

  fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .RAE(RA1E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_a)
  );

  fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .RAE(RA2E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  assign memop   = MemtoRegM | MemWriteM;
  assign lwstall = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
  // No access may be issued while reset is held, even though state is already idle.
  assign MemReq  = reset & memop;

  always_comb begin
    next_state = state;
    next_wait  = wait_cnt;
    memstall   = 1'b0;
    set_err    = 1'b0;
    unique case (state)
      MEM_IDLE: begin
        if (MemReq && !MemAck) begin
          next_state = MEM_WAIT;
          next_wait  = WT_W'(1);
          memstall   = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MemAck) begin
          next_state = MEM_IDLE;
        end else if (wait_cnt == TIMEOUT_V) begin
          // Abandon the access and let the pipeline move on; the error is sticky.
          next_state = MEM_IDLE;
          set_err    = 1'b1;
        end else begin
          memstall  = 1'b1;
          next_wait = wait_cnt + WT_W'(1);
        end
      end
      default: next_state = MEM_IDLE;
    endcase
  end

  // Memory stall freezes E, so branch/load-use effects wait for the first free cycle.
  assign StallF = memstall | (lwstall & ~BranchTakenE);
  assign StallD = StallF;
  assign StallE = memstall;
  assign StallM = memstall;
  assign FlushW = memstall;
  assign FlushD = ~memstall & BranchTakenE;
  assign FlushE = ~memstall & (BranchTakenE | lwstall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= MEM_IDLE;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state    <= next_state;
      wait_cnt <= next_wait;
      if (set_err) MemErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushE && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of combinational hazard vectors plus
// hand-written sequences for memory wait, timeout, reset and counter saturation.
module tb_hazard_ctrl;

  localparam int RA_W = 4;
  localparam int CNT_W = 8;
  localparam int MEM_TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  logic [RA_W-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic BranchTakenE, MemAck, CntClr;
  logic MemReq, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchTakenE(BranchTakenE), .MemAck(MemAck), .CntClr(CntClr),
    .MemReq(MemReq), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  typedef struct {
    logic [3:0] ra1e, ra2e, wa3m, wa3w;
    logic       rwm, rww;
    logic [3:0] ra1d, ra2d, wa3e;
    logic       rwe, mtre, bt;
    logic [1:0] fae, fbe;
    logic       sf, fd, fe;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM} = '0;
    {BranchTakenE, MemAck, CntClr} = '0;
  endtask

  task automatic set_loaduse();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd1; RA2D = 4'd5;
  endtask

  task automatic clear_counters();
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
  endtask

  initial begin
    //        ra1e ra2e wa3m wa3w rwm rww ra1d ra2d wa3e rwe mtre bt  fae    fbe    sf fd fe
    vecs[0] = '{4'd3, 4'd7, 4'd3, 4'd3, 1, 1, 4'd1, 4'd2, 4'd5, 1, 1, 0, 2'b10, 2'b00, 0, 0, 0};
    vecs[1] = '{4'd3, 4'd7, 4'd3, 4'd3, 0, 1, 4'd1, 4'd2, 4'd5, 1, 1, 0, 2'b01, 2'b00, 0, 0, 0};
    vecs[2] = '{4'd3, 4'd7, 4'd7, 4'd3, 1, 1, 4'd0, 4'd0, 4'd9, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0};
    vecs[3] = '{4'd4, 4'd3, 4'd3, 4'd3, 1, 0, 4'd0, 4'd0, 4'd9, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0};
    vecs[4] = '{4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd1, 4'd5, 4'd5, 1, 1, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[5] = '{4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd5, 4'd0, 4'd5, 1, 1, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[6] = '{4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd5, 4'd0, 4'd5, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[7] = '{4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd5, 4'd0, 4'd5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[8] = '{4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd1, 4'd5, 4'd5, 1, 1, 1, 2'b00, 2'b00, 0, 1, 1};
    vecs[9] = '{4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd1, 4'd2, 4'd5, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1};

    // Reset state
    idle_inputs();
    reset = 1'b0;
    #12;
    check("rst_stallcnt", 32'(StallCnt), 0);
    check("rst_flushcnt", 32'(FlushCnt), 0);
    check("rst_memerr", 32'(MemErr), 0);
    check("rst_stall", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReq}), 0);
    reset = 1'b1;
    tick();

    // Combinational hazard vectors
    for (int i = 0; i < 10; i++) begin
      RA1E = vecs[i].ra1e; RA2E = vecs[i].ra2e; WA3M = vecs[i].wa3m; WA3W = vecs[i].wa3w;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      RA1D = vecs[i].ra1d; RA2D = vecs[i].ra2d; WA3E = vecs[i].wa3e;
      RegWriteE = vecs[i].rwe; MemtoRegE = vecs[i].mtre; BranchTakenE = vecs[i].bt;
      #2;
      check($sformatf("v%0d_fae", i), 32'(ForwardAE), 32'(vecs[i].fae));
      check($sformatf("v%0d_fbe", i), 32'(ForwardBE), 32'(vecs[i].fbe));
      check($sformatf("v%0d_stallfd", i), 32'({StallF, StallD}), 32'({vecs[i].sf, vecs[i].sf}));
      check($sformatf("v%0d_flushde", i), 32'({FlushD, FlushE}), 32'({vecs[i].fd, vecs[i].fe}));
      check($sformatf("v%0d_memside", i), 32'({StallE, StallM, FlushW, MemReq}), 0);
    end
    idle_inputs();
    tick();
    clear_counters();

    // Load-use for one cycle
    set_loaduse();
    tick();
    idle_inputs();
    check("lu_stallcnt", 32'(StallCnt), 1);
    check("lu_flushcnt", 32'(FlushCnt), 1);

    // Branch masks load-use
    set_loaduse();
    BranchTakenE = 1'b1;
    tick();
    idle_inputs();
    check("br_stallcnt", 32'(StallCnt), 1);
    check("br_flushcnt", 32'(FlushCnt), 2);

    // Multi-cycle load; a branch arriving mid-stall must not flush
    clear_counters();
    MemtoRegM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      BranchTakenE = (i == 1);
      #1;
      check($sformatf("mw%0d_stall", i), 32'({StallF, StallD, StallE, StallM, FlushW, MemReq}), 32'h3f);
      check($sformatf("mw%0d_flush", i), 32'({FlushD, FlushE}), 0);
      tick();
    end
    BranchTakenE = 1'b0;
    MemAck = 1'b1;
    #1;
    check("mw_ack_stall", 32'({StallF, StallE, FlushW}), 0);
    check("mw_ack_req", 32'(MemReq), 1);
    tick();
    idle_inputs();
    check("mw_stallcnt", 32'(StallCnt), 3);
    check("mw_flushcnt", 32'(FlushCnt), 0);

    // Single-cycle access: no stall
    MemtoRegM = 1'b1; MemAck = 1'b1;
    #1;
    check("sc_stall", 32'({StallF, FlushW}), 0);
    tick();
    idle_inputs();
    check("sc_stallcnt", 32'(StallCnt), 3);

    // Timeout on a store that is never acknowledged
    clear_counters();
    MemWriteM = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      check($sformatf("to%0d_stall", i), 32'(StallF), 1);
      tick();
    end
    check("to_release", 32'(StallF), 0);
    check("to_err_early", 32'(MemErr), 0);
    tick();
    MemWriteM = 1'b0;
    check("to_err", 32'(MemErr), 1);
    check("to_stallcnt", 32'(StallCnt), 4);
    MemtoRegM = 1'b1; MemAck = 1'b1;
    #1;
    check("to_idle_access", 32'(StallF), 0);
    tick();
    idle_inputs();
    tick();
    check("to_err_sticky", 32'(MemErr), 1);

    // Asynchronous reset in the middle of a wait
    MemtoRegM = 1'b1;
    tick();
    tick();
    check("ar_waiting", 32'(StallF), 1);
    #2 reset = 1'b0;
    #1;
    check("ar_outputs", 32'({StallF, StallD, StallE, StallM, FlushW, MemReq}), 0);
    check("ar_counters", 32'({StallCnt, FlushCnt}), 0);
    check("ar_memerr", 32'(MemErr), 0);
    MemAck = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("ar_after_access", 32'({StallF, MemReq}), 32'h1);
    tick();
    idle_inputs();
    check("ar_after_cnt", 32'(StallCnt), 0);

    // Counter saturation, then clear taking priority over increment
    set_loaduse();
    for (int i = 0; i < 260; i++) tick();
    check("sat_stallcnt", 32'(StallCnt), 255);
    check("sat_flushcnt", 32'(FlushCnt), 255);
    CntClr = 1'b1;
    tick();
    check("clr_priority", 32'({StallCnt, FlushCnt}), 0);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
